// File: rtl/ultrasonic_ranger.sv
// Multi-channel HC-SR04 ranging engine: round-robin trigger slots, echo width in us, intensity level per channel.
// Latency: echo edge reaches the counter 3 clk later; slot results publish one clk after the final slot tick.
// Backpressure: none; sample_valid is a one-cycle strobe, and sample_* and intensity hold until the next publish.
module ultrasonic_ranger #(
   parameter int CLK_HZ    = 40_000_000,
   parameter int NUM_CH    = 2,
   parameter int PERIOD_US = 60000,
   parameter int TRIG_US   = 20,
   parameter int MAX_US    = 3552,
   parameter int LEVELS    = 9,
   parameter int CNT_W     = 12,
   parameter int LVL_W     = 4,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         echo,
   output logic [NUM_CH-1:0]         trig,
   output logic [NUM_CH*LVL_W-1:0]   intensity,
   output logic                      sample_valid,
   output logic [CH_W-1:0]           sample_ch,
   output logic [CNT_W-1:0]          sample_us,
   output logic                      sample_miss
);

   // Clock cycles per microsecond and derived counter widths.
   localparam int DIV    = CLK_HZ / 1_000_000;
   localparam int PS_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SLOT_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
   // Width of one intensity band; level k covers widths ((LEVELS-1-k)*STEP, (LEVELS-k)*STEP].
   localparam int STEP   = MAX_US / (LEVELS - 1);

   typedef enum logic [1:0] {
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_DONE
   } state_t;

   // ------------------------------------------------------------------
   // Microsecond tick: a clock enable, never a derived clock.
   // ------------------------------------------------------------------
   logic [PS_W-1:0] psc;
   logic            tick;

   assign tick = (psc == PS_W'(DIV - 1));

   // Prescaler counts 0..DIV-1 and wraps on the tick cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psc <= '0;
      end else if (tick) begin
         psc <= '0;
      end else begin
         psc <= psc + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Echo synchronisation and edge detection (all channels).
   // ------------------------------------------------------------------
   logic [NUM_CH-1:0] sync1;
   logic [NUM_CH-1:0] sync2;
   logic [NUM_CH-1:0] echo_d;

   // Two-flop synchroniser plus a delayed copy for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1  <= '0;
         sync2  <= '0;
         echo_d <= '0;
      end else begin
         sync1  <= echo;
         sync2  <= sync1;
         echo_d <= sync2;
      end
   end

   // ------------------------------------------------------------------
   // Slot timing and active channel.
   // ------------------------------------------------------------------
   logic [SLOT_W-1:0] slot_us;
   logic [CH_W-1:0]   cur_ch;
   logic              slot_end;

   assign slot_end = tick && (slot_us == SLOT_W'(PERIOD_US - 1));

   // Slot counter advances each tick; the channel rotates on the last tick of a slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_us <= '0;
         cur_ch  <= '0;
      end else if (slot_end) begin
         slot_us <= '0;
         cur_ch  <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
      end else if (tick) begin
         slot_us <= slot_us + 1'b1;
      end
   end

   // Only the active channel's echo is looked at; others are ignored entirely.
   logic echo_lvl;
   logic echo_rise;
   logic echo_fall;

   assign echo_lvl  = sync2[cur_ch];
   assign echo_rise = sync2[cur_ch] & ~echo_d[cur_ch];
   assign echo_fall = ~sync2[cur_ch] & echo_d[cur_ch];

   // Registered trigger: one-hot on the active channel for the first TRIG_US us of the slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trig <= '0;
      end else begin
         trig <= '0;
         if (slot_us < SLOT_W'(TRIG_US)) begin
            trig[cur_ch] <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-slot measurement FSM.
   // ------------------------------------------------------------------
   state_t           state;
   logic [CNT_W-1:0] width;
   logic [CNT_W-1:0] width_nxt;
   logic             rise_seen;

   // Staging registers between slot end and publish.
   logic             pub_pend;
   logic [CNT_W-1:0] pub_us;
   logic             pub_miss;
   logic [CH_W-1:0]  pub_ch;

   // Width counts ticks while the synced echo is high, saturating at all-ones.
   always_comb begin
      width_nxt = width;
      if ((state == S_MEASURE) && tick && echo_lvl && (width != {CNT_W{1'b1}})) begin
         width_nxt = width + 1'b1;
      end
   end

   // Slot end overrides every state: stage the result, clear the width and restart in TRIG.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_TRIG;
         width     <= '0;
         rise_seen <= 1'b0;
         pub_pend  <= 1'b0;
         pub_us    <= '0;
         pub_miss  <= 1'b0;
         pub_ch    <= '0;
      end else if (slot_end) begin
         pub_pend  <= 1'b1;
         pub_us    <= width_nxt;
         pub_miss  <= ~rise_seen;
         pub_ch    <= cur_ch;
         width     <= '0;
         rise_seen <= 1'b0;
         state     <= S_TRIG;
      end else begin
         pub_pend <= 1'b0;
         width    <= width_nxt;
         case (state)
            S_TRIG: begin
               if (slot_us >= SLOT_W'(TRIG_US)) begin
                  state <= S_WAIT_RISE;
               end
            end
            S_WAIT_RISE: begin
               if (echo_rise) begin
                  rise_seen <= 1'b1;
                  state     <= S_MEASURE;
               end
            end
            S_MEASURE: begin
               if (echo_fall) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_TRIG;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Width to intensity: comparator chain, level = thresholds not exceeded.
   // ------------------------------------------------------------------
   logic [LEVELS-2:0] under;
   logic [LVL_W-1:0]  pub_lvl;

   for (genvar k = 1; k < LEVELS; k++) begin : g_thresh
      assign under[k-1] = (pub_us <= CNT_W'(k * STEP));
   end

   // Count satisfied thresholds; a zero width (no echo) maps to level 0.
   always_comb begin
      pub_lvl = '0;
      for (int k = 0; k < LEVELS - 1; k++) begin
         pub_lvl = pub_lvl + LVL_W'(under[k]);
      end
      if (pub_us == '0) begin
         pub_lvl = '0;
      end
   end

   // Publish the staged result with a one-cycle valid strobe; outputs hold otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_valid <= 1'b0;
         sample_ch    <= '0;
         sample_us    <= '0;
         sample_miss  <= 1'b0;
         intensity    <= '0;
      end else begin
         sample_valid <= pub_pend;
         if (pub_pend) begin
            sample_ch                          <= pub_ch;
            sample_us                          <= pub_us;
            sample_miss                        <= pub_miss;
            intensity[pub_ch*LVL_W +: LVL_W]   <= pub_lvl;
         end
      end
   end

endmodule
